// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants for the HI/LO multiply/divide controller.
// Funct codes, FSM state encodings and the HI/LO-class decode helper.
package muldiv_ctrl_pkg;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1a;
  localparam logic [5:0] DIVU  = 6'h1b;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_MUL  = 2'd1;
  localparam logic [1:0] MD_DIV  = 2'd2;
  localparam logic [1:0] MD_FIX  = 2'd3;

  function automatic logic is_hilo(logic [5:0] f);
    return (f == MFHI) || (f == MTHI) ||
           (f == MFLO) || (f == MTLO) ||
           (f == MULT) || (f == MULTU) ||
           (f == DIV)  || (f == DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring divider datapath: one quotient bit per step.
// Ports: clk, rst, load (init), step (iterate), dividend, divisor, quo, rem.
module div_iter
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic [31:0] dsr;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;

  // rem < dsr always holds, so the shifted value fits in 33 bits
  // and diff[32] is a clean borrow flag.
  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dsr};
    ge      = ~diff[32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (step) begin
      quo <= {quo[30:0], ge};
      rem <= ge ? diff[31:0] : shifted[31:0];
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller beside EX: FSM, signs, HI/LO, stall.
// Ports: clk, rst, req_valid, funct, src_a, src_b, flush -> stall, busy, hi, lo.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [5:0]  funct,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_signed;
  logic        q_neg;
  logic        r_neg;
  logic        dz;

  logic        hilo;
  logic        accept;
  logic        is_mul;
  logic        is_div;
  logic        sgn;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        load;
  logic        step;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [63:0] sa;
  logic [63:0] sb;
  logic [63:0] prod;
  logic [31:0] fix_q;
  logic [31:0] fix_r;

  assign hilo   = is_hilo(funct);
  assign busy   = (state != MD_IDLE);
  assign stall  = req_valid && hilo && busy;
  assign accept = req_valid && hilo && !stall && !flush;

  assign is_mul = (funct == MULT) || (funct == MULTU);
  assign is_div = (funct == DIV) || (funct == DIVU);
  assign sgn    = (funct == MULT) || (funct == DIV);

  assign mag_a = (sgn && src_a[31]) ? -src_a : src_a;
  assign mag_b = (sgn && src_b[31]) ? -src_b : src_b;

  assign load = accept && is_div;
  assign step = (state == MD_DIV) && !flush;

  // Sign-extending only for signed ops lets one 64-bit
  // multiply serve both MULT and MULTU.
  always_comb begin
    sa    = {{32{op_a[31] & op_signed}}, op_a};
    sb    = {{32{op_b[31] & op_signed}}, op_b};
    prod  = sa * sb;
    fix_q = q_neg ? -quo : quo;
    fix_r = r_neg ? -rem : rem;
  end

  div_iter u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo      (quo),
    .rem      (rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz        <= 1'b0;
    end else if (flush) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        MD_IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_mul: begin
                state     <= MD_MUL;
                cnt       <= '0;
                op_a      <= src_a;
                op_b      <= src_b;
                op_signed <= sgn;
              end
              is_div: begin
                state <= MD_DIV;
                cnt   <= '0;
                op_a  <= src_a;
                q_neg <= sgn && (src_a[31] ^ src_b[31]);
                r_neg <= sgn && src_a[31];
                dz    <= (src_b == '0);
              end
              (funct == MTHI): hi <= src_a;
              (funct == MTLO): lo <= src_a;
              default: ;
            endcase
          end
        end
        MD_MUL: begin
          if (cnt == MUL_LAST) begin
            {hi, lo} <= prod;
            state    <= MD_IDLE;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        MD_DIV: begin
          if (cnt == 6'd31) begin
            state <= MD_FIX;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        MD_FIX: begin
          // Divide by zero reports all-ones quotient and raw dividend.
          lo    <= dz ? 32'hFFFF_FFFF : fix_q;
          hi    <= dz ? op_a : fix_r;
          state <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized + directed bench for muldiv_ctrl against an arithmetic model.
// Model tracks HI/LO, remaining busy cycles and the pending result.
module tb_muldiv_ctrl;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [5:0]  funct;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left;
  logic        st_seen;

  logic [5:0] fpool [10] = '{6'h10, 6'h11, 6'h12, 6'h13,
                             6'h18, 6'h19, 6'h1a, 6'h1b,
                             6'h20, 6'h00};

  muldiv_ctrl #(.MUL_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .funct     (funct),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  function automatic logic cls(logic [5:0] f);
    return f inside {6'h10, 6'h11, 6'h12, 6'h13,
                     6'h18, 6'h19, 6'h1a, 6'h1b};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = '0;
    m_lo = '0;
    m_left = 0;
  endtask

  task automatic model_step();
    longint      ps;
    logic [63:0] pu;
    int          sa, sb;
    if (flush) begin
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (req_valid && cls(funct)) begin
      case (funct)
        6'h11: m_hi = src_a;
        6'h13: m_lo = src_a;
        6'h18: begin
          ps = longint'($signed(src_a)) * longint'($signed(src_b));
          {p_hi, p_lo} = ps;
          m_left = LAT;
        end
        6'h19: begin
          pu = {32'b0, src_a} * {32'b0, src_b};
          {p_hi, p_lo} = pu;
          m_left = LAT;
        end
        6'h1a: begin
          sa = $signed(src_a);
          sb = $signed(src_b);
          if (src_b == 0) begin
            p_lo = 32'hFFFF_FFFF;
            p_hi = src_a;
          end else if (src_a == 32'h8000_0000 && src_b == 32'hFFFF_FFFF) begin
            p_lo = 32'h8000_0000;
            p_hi = 0;
          end else begin
            p_lo = sa / sb;
            p_hi = sa % sb;
          end
          m_left = 33;
        end
        6'h1b: begin
          if (src_b == 0) begin
            p_lo = 32'hFFFF_FFFF;
            p_hi = src_a;
          end else begin
            p_lo = src_a / src_b;
            p_hi = src_a % src_b;
          end
          m_left = 33;
        end
        default: ;
      endcase
    end
  endtask

  // Called at a negedge: drive, compare, clock, update model.
  task automatic cyc(logic rv, logic [5:0] f, logic [31:0] a,
                     logic [31:0] b, logic fl);
    logic exp_st;
    req_valid = rv;
    funct = f;
    src_a = a;
    src_b = b;
    flush = fl;
    #1;
    exp_st = rv && cls(f) && (m_left > 0);
    st_seen = stall;
    chk("stall", {31'b0, stall}, {31'b0, exp_st});
    chk("busy", {31'b0, busy}, {31'b0, m_left > 0});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 6'h00, '0, '0, 1'b0);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] sp [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
    case ($urandom_range(0, 3))
      0: return sp[$urandom_range(0, 3)];
      1: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb, ns;
    rst = 1'b1;
    req_valid = 1'b0;
    funct = '0;
    src_a = '0;
    src_b = '0;
    flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    rst = 1'b0;

    cyc(1'b1, 6'h18, 32'hFFFF_FFFF, 32'h2, 1'b0);
    idle(1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    cyc(1'b1, 6'h19, 32'hFFFF_FFFF, 32'h2, 1'b0);
    idle(1);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    cyc(1'b1, 6'h1a, 32'hFFFF_FFF9, 32'h2, 1'b0);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      idle(1);
    end
    chk("div_busy_cycles", 32'(nb), 32'd33);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    cyc(1'b1, 6'h1b, 32'd100, 32'd7, 1'b0);
    idle(33);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    cyc(1'b1, 6'h1b, 32'h1234, 32'h0, 1'b0);
    idle(33);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'h1234);

    cyc(1'b1, 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(33);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    cyc(1'b1, 6'h1b, 32'd1000, 32'd10, 1'b0);
    idle(1);
    ns = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 6'h12, '0, '0, 1'b0);
      if (!st_seen) break;
      ns++;
    end
    chk("mflo_stall_cycles", 32'(ns), 32'd32);
    chk("mflo_val", lo, 32'd100);

    cyc(1'b1, 6'h1b, 32'd50, 32'd5, 1'b0);
    idle(3);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 6'h1b, 32'd77, 32'd7, 1'b0);
      if (!st_seen) break;
    end
    chk("b2b_first_lo", lo, 32'd10);
    idle(33);
    chk("b2b_lo", lo, 32'd11);
    chk("b2b_hi", hi, 32'd0);

    cyc(1'b1, 6'h11, 32'hA5A5_A5A5, '0, 1'b0);
    req_valid = 1'b1;
    funct = 6'h10;
    #1;
    chk("mfhi_stall", {31'b0, stall}, 32'h0);
    chk("mfhi_val", hi, 32'hA5A5_A5A5);
    cyc(1'b1, 6'h10, '0, '0, 1'b0);

    cyc(1'b1, 6'h13, 32'h55, '0, 1'b0);
    cyc(1'b1, 6'h1a, 32'd1000, 32'd3, 1'b0);
    idle(9);
    cyc(1'b0, 6'h00, '0, '0, 1'b1);
    #1;
    chk("flush_busy", {31'b0, busy}, 32'h0);
    chk("flush_lo", lo, 32'h55);

    cyc(1'b1, 6'h1b, 32'd12345, 32'd6, 1'b0);
    idle(19);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 6'h19, 32'd3, 32'd5, 1'b0);
    idle(1);
    chk("post_rst_lo", lo, 32'd15);
    chk("post_rst_hi", hi, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          fpool[$urandom_range(0, 9)],
          rnd_op(), rnd_op(),
          1'($urandom_range(0, 39) == 0));
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
